// File: rtl/aemb_mult_pkg.sv
// AEMB multiplier shared definitions.
// Mode encoding and operand signedness helpers.
package aemb_mult_pkg;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULH   = 2'b01,
        MODE_MULHSU = 2'b10,
        MODE_MULHU  = 2'b11
    } mode_t;

    function automatic logic a_signed(mode_t m);
        return (m == MODE_MULH) || (m == MODE_MULHSU);
    endfunction

    function automatic logic b_signed(mode_t m);
        return (m == MODE_MULH);
    endfunction

endpackage

// File: rtl/aemb_mult_pipe_if.sv
// AEMB multiplier X-stage request / MA-stage result bundle.
// The master drives the operands, the slave returns results.
interface aemb_mult_pipe_if #(
    parameter int DW   = 32,
    parameter int TAGW = 5
);
    logic            x_vld;
    logic [1:0]      x_mode;
    logic [DW-1:0]   x_opa;
    logic [DW-1:0]   x_opb;
    logic [TAGW-1:0] x_tag;
    logic            x_flush;
    logic [DW-1:0]   m_mul;
    logic            m_vld;
    logic [TAGW-1:0] m_tag;
    logic            m_busy;

    modport master (
        output x_vld, x_mode, x_opa, x_opb, x_tag, x_flush,
        input  m_mul, m_vld, m_tag, m_busy
    );

    modport slave (
        input  x_vld, x_mode, x_opa, x_opb, x_tag, x_flush,
        output m_mul, m_vld, m_tag, m_busy
    );
endinterface

// File: rtl/aemb_mult_dly.sv
// Enabled, flushable shift line for the multiplier control bits.
// Flush clears every valid bit behind the entry stage.
module aemb_mult_dly #(
    parameter int W = 7,
    parameter int N = 2
) (
    input  logic         gclk,
    input  logic         grst,
    input  logic         ena,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic [N-1:0] vld,
    output logic [W-1:0] out_dat
);

    logic [W-1:0] dat [N];

    always_ff @(posedge gclk) begin
        if (grst) begin
            vld <= '0;
            for (int i = 0; i < N; i++)
                dat[i] <= '0;
        end else if (ena) begin
            vld[0] <= in_vld;
            dat[0] <= in_dat;
            for (int i = 1; i < N; i++) begin
                vld[i] <= flush ? 1'b0 : vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_dat = dat[N-1];

endmodule

// File: rtl/aemb_mult_pipe.sv
// AEMB pipelined integer multiplier for the execute path.
// Stage 1 multiplies, later stages only delay the product.
module aemb_mult_pipe
    import aemb_mult_pkg::*;
#(
    parameter int MUL    = 1,
    parameter int DW     = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          gena,
    aemb_mult_pipe_if.slave io
);

    generate
        if (MUL != 0) begin : g_mul
            localparam int CW = 2 + TAGW;

            mode_t                  x_mode;
            logic signed [DW:0]     a_ext;
            logic signed [DW:0]     b_ext;
            logic signed [2*DW+1:0] full;
            logic [2*DW-1:0]        prod [STAGES];
            logic [STAGES-1:0]      vld;
            logic [CW-1:0]          ctl;
            logic [1:0]             o_mode;
            logic [TAGW-1:0]        o_tag;
            logic                   unused_hi;

            assign x_mode = mode_t'(io.x_mode);

            // One extra bit lets a single signed multiply cover all modes
            assign a_ext = {a_signed(x_mode) & io.x_opa[DW-1], io.x_opa};
            assign b_ext = {b_signed(x_mode) & io.x_opb[DW-1], io.x_opb};
            assign full  = a_ext * b_ext;
            assign unused_hi = ^full[2*DW+1:2*DW];

            always_ff @(posedge gclk) begin
                if (grst) begin
                    for (int i = 0; i < STAGES; i++)
                        prod[i] <= '0;
                end else if (gena) begin
                    prod[0] <= full[2*DW-1:0];
                    for (int i = 1; i < STAGES; i++)
                        prod[i] <= prod[i-1];
                end
            end

            aemb_mult_dly #(
                .W (CW),
                .N (STAGES)
            ) u_dly (
                .gclk    (gclk),
                .grst    (grst),
                .ena     (gena),
                .flush   (io.x_flush),
                .in_vld  (io.x_vld),
                .in_dat  ({io.x_mode, io.x_tag}),
                .vld     (vld),
                .out_dat (ctl)
            );

            assign {o_mode, o_tag} = ctl;

            assign io.m_mul  = (o_mode == MODE_MUL)
                             ? prod[STAGES-1][DW-1:0]
                             : prod[STAGES-1][2*DW-1:DW];
            assign io.m_vld  = vld[STAGES-1];
            assign io.m_tag  = o_tag;
            assign io.m_busy = |vld[STAGES-2:0];
        end else begin : g_nomul
            logic unused_in;

            assign unused_in = ^{gclk, grst, gena, io.x_vld,
                                 io.x_mode, io.x_opa, io.x_opb,
                                 io.x_tag, io.x_flush};

            assign io.m_mul  = '0;
            assign io.m_vld  = 1'b0;
            assign io.m_tag  = '0;
            assign io.m_busy = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_aemb_mult_pipe.sv
// Scoreboard bench for aemb_mult_pipe: STAGES=2/DW=32,
// STAGES=4/DW=16 and a MUL=0 instance.
module tb_aemb_mult_pipe;

    logic gclk = 1'b0;
    logic grst;
    logic gena;
    logic adv;

    int checks = 0;
    int errors = 0;

    logic [36:0] q2 [$];
    logic [20:0] q4 [$];

    always #5 gclk = ~gclk;

    aemb_mult_pipe_if #(.DW(32), .TAGW(5)) if2 ();
    aemb_mult_pipe_if #(.DW(16), .TAGW(5)) if4 ();
    aemb_mult_pipe_if #(.DW(32), .TAGW(5)) if0 ();

    aemb_mult_pipe #(.MUL(1), .DW(32), .STAGES(2), .TAGW(5)) u2 (
        .gclk (gclk), .grst (grst), .gena (gena), .io (if2.slave)
    );

    aemb_mult_pipe #(.MUL(1), .DW(16), .STAGES(4), .TAGW(5)) u4 (
        .gclk (gclk), .grst (grst), .gena (gena), .io (if4.slave)
    );

    aemb_mult_pipe #(.MUL(0), .DW(32), .STAGES(2), .TAGW(5)) u0 (
        .gclk (gclk), .grst (grst), .gena (gena), .io (if0.slave)
    );

    assign if0.x_vld   = if2.x_vld;
    assign if0.x_mode  = if2.x_mode;
    assign if0.x_opa   = if2.x_opa;
    assign if0.x_opb   = if2.x_opb;
    assign if0.x_tag   = if2.x_tag;
    assign if0.x_flush = if2.x_flush;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model16(logic [1:0] m,
                                            logic [15:0] a,
                                            logic [15:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (m == 2'b01 || m == 2'b10) sa = longint'($signed(a));
        if (m == 2'b01) sb = longint'($signed(b));
        p = sa * sb;
        return (m == 2'b00) ? p[15:0] : p[31:16];
    endfunction

    // A result is consumed once, on the first sample after an enabled edge
    always @(posedge gclk) adv <= gena && !grst;

    always @(negedge gclk) begin
        logic [36:0] e;
        if (adv && if2.m_vld) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u2_unexpected: got tag %0d data %h, required none",
                         if2.m_tag, if2.m_mul);
            end else begin
                e = q2.pop_front();
                chk("u2_mul", if2.m_mul, e[31:0]);
                chk("u2_tag", 32'(if2.m_tag), 32'(e[36:32]));
            end
            chk("u0_mul", if0.m_mul, 32'h0);
            chk("u0_vld", 32'(if0.m_vld), 32'h0);
        end
    end

    always @(negedge gclk) begin
        logic [20:0] e;
        if (adv && if4.m_vld) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u4_unexpected: got tag %0d data %h, required none",
                         if4.m_tag, if4.m_mul);
            end else begin
                e = q4.pop_front();
                chk("u4_mul", 32'(if4.m_mul), 32'(e[15:0]));
                chk("u4_tag", 32'(if4.m_tag), 32'(e[20:16]));
            end
        end
    end

    task automatic op2(logic [1:0] m, logic [31:0] a, logic [31:0] b,
                       logic [4:0] t, logic [31:0] exp, bit push);
        @(negedge gclk);
        if2.x_vld   = 1'b1;
        if2.x_mode  = m;
        if2.x_opa   = a;
        if2.x_opb   = b;
        if2.x_tag   = t;
        if2.x_flush = 1'b0;
        if (push) q2.push_back({t, exp});
    endtask

    task automatic op4(logic [1:0] m, logic [15:0] a, logic [15:0] b,
                       logic [4:0] t, logic [15:0] exp, bit push, bit fl);
        @(negedge gclk);
        if4.x_vld   = 1'b1;
        if4.x_mode  = m;
        if4.x_opa   = a;
        if4.x_opb   = b;
        if4.x_tag   = t;
        if4.x_flush = fl;
        if (push) q4.push_back({t, exp});
    endtask

    task automatic idle2();
        @(negedge gclk);
        if2.x_vld   = 1'b0;
        if2.x_flush = 1'b0;
    endtask

    task automatic idle4();
        @(negedge gclk);
        if4.x_vld   = 1'b0;
        if4.x_flush = 1'b0;
    endtask

    task automatic chk_zero4(string pfx);
        chk({pfx, "_vld"},  32'(if4.m_vld), 32'h0);
        chk({pfx, "_busy"}, 32'(if4.m_busy), 32'h0);
        chk({pfx, "_mul"},  32'(if4.m_mul), 32'h0);
        chk({pfx, "_tag"},  32'(if4.m_tag), 32'h0);
    endtask

    initial begin
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  t;
        int          n;

        grst = 1'b1;
        gena = 1'b1;
        if2.x_vld = 1'b0; if2.x_mode = '0; if2.x_opa = '0;
        if2.x_opb = '0;   if2.x_tag = '0;  if2.x_flush = 1'b0;
        if4.x_vld = 1'b0; if4.x_mode = '0; if4.x_opa = '0;
        if4.x_opb = '0;   if4.x_tag = '0;  if4.x_flush = 1'b0;
        repeat (3) @(negedge gclk);

        chk("rst_u2_vld",  32'(if2.m_vld), 32'h0);
        chk("rst_u2_busy", 32'(if2.m_busy), 32'h0);
        chk("rst_u2_mul",  if2.m_mul, 32'h0);
        chk("rst_u2_tag",  32'(if2.m_tag), 32'h0);
        chk_zero4("rst_u4");
        chk("rst_u0_vld",  32'(if0.m_vld), 32'h0);
        grst = 1'b0;

        // Latency: visible after the second enabled edge
        op2(2'b00, 32'h7, 32'h6, 5'd3, 32'h0000002A, 1);
        idle2();
        chk("lat_e1_vld", 32'(if2.m_vld), 32'h0);
        chk("lat_e1_busy", 32'(if2.m_busy), 32'h1);
        @(negedge gclk);
        chk("lat_e2_vld", 32'(if2.m_vld), 32'h1);
        chk("lat_e2_mul", if2.m_mul, 32'h0000002A);
        chk("lat_e2_tag", 32'(if2.m_tag), 32'd3);

        // All-ones operands in every mode, back to back
        op2(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 1);
        op2(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1);
        op2(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 1);
        op2(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001, 1);
        op2(2'b11, 32'h00010000, 32'h00010000, 5'd6, 32'h00000001, 1);
        op2(2'b01, 32'h80000000, 32'h00000002, 5'd8, 32'hFFFFFFFF, 1);
        idle2();
        repeat (3) @(negedge gclk);

        // Freeze with the op in stage 1; a flush while frozen is ignored
        op2(2'b00, 32'h1234, 32'h10, 5'd7, 32'h00012340, 1);
        @(negedge gclk);
        if2.x_vld = 1'b0;
        gena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            if2.x_flush = (i == 1);
            chk("frz_vld", 32'(if2.m_vld), 32'h0);
            chk("frz_busy", 32'(if2.m_busy), 32'h1);
        end
        if2.x_flush = 1'b0;
        gena = 1'b1;
        @(negedge gclk);
        chk("frz_out_vld", 32'(if2.m_vld), 32'h1);
        chk("frz_out_mul", if2.m_mul, 32'h00012340);
        @(negedge gclk);
        chk("frz_nodup_vld", 32'(if2.m_vld), 32'h0);
        chk("frz_nodup_busy", 32'(if2.m_busy), 32'h0);

        // Four-stage latency, signed by unsigned high half
        op4(2'b10, 16'h8000, 16'hFFFF, 5'd9, 16'h8000, 1, 0);
        idle4();
        chk("l4_e1_vld", 32'(if4.m_vld), 32'h0);
        @(negedge gclk);
        chk("l4_e2_vld", 32'(if4.m_vld), 32'h0);
        @(negedge gclk);
        chk("l4_e3_vld", 32'(if4.m_vld), 32'h0);
        chk("l4_e3_busy", 32'(if4.m_busy), 32'h1);
        @(negedge gclk);
        chk("l4_e4_vld", 32'(if4.m_vld), 32'h1);
        chk("l4_e4_mul", 32'(if4.m_mul), 32'h8000);
        chk("l4_e4_busy", 32'(if4.m_busy), 32'h0);

        // Flush kills older ops, the op issued with it survives
        op4(2'b00, 16'h1111, 16'h0002, 5'd1, 16'h0, 0, 0);
        op4(2'b00, 16'h2222, 16'h0003, 5'd2, 16'h0, 0, 0);
        op4(2'b00, 16'h0010, 16'h0010, 5'd6, 16'h0100, 1, 1);
        idle4();
        repeat (5) @(negedge gclk);

        // Reset mid-pipeline drops everything in flight
        op4(2'b11, 16'hABCD, 16'h1234, 5'd11, 16'h0, 0, 0);
        op4(2'b01, 16'h7FFF, 16'h7FFF, 5'd12, 16'h0, 0, 0);
        idle4();
        grst = 1'b1;
        @(negedge gclk);
        chk_zero4("mid_rst");
        grst = 1'b0;
        repeat (5) @(negedge gclk);

        // Model comparison on the four-stage instance
        for (int i = 0; i < 24; i++) begin
            m = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            t = 5'($urandom);
            op4(m, a, b, t, model16(m, a, b), 1, 0);
        end
        idle4();

        n = 0;
        while ((q2.size() != 0 || q4.size() != 0) && n < 50) begin
            @(negedge gclk);
            n++;
        end
        checks++;
        if (q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending, required 0",
                     q2.size(), q4.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
